// File: rtl/uart_pkg.sv
// Shared defaults, FSM encoding and grant helper for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } tx_state_e;

  // Alternate on contention, otherwise serve whichever requester has data.
  function automatic logic pick_grant(input logic avail0, input logic avail1,
                                      input logic last_grant);
    if (avail0 && avail1) return ~last_grant;
    return avail1;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Per-requester byte FIFO; ready is registered so it reads low throughout reset.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data_c,
  output logic                     ready,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              do_push;
  logic              do_pop;

  assign full_c     = (count == FULL_CNT);
  assign empty_c    = (count == '0);
  assign do_push    = push && !full_c;
  assign do_pop     = pop && !empty_c;
  assign pop_data_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Ready follows the post-edge count, so a pop while full frees space one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      ready <= (count_nxt < FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single byte stream to the UART transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              uart_samplig_clk,
  input  logic              reset,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_src
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              push0, push1, pop0, pop1;
  logic [DATA_W-1:0] data0_c, data1_c;
  logic              full0_c, full1_c, empty0_c, empty1_c;
  logic [CNT_W-1:0]  count0, count1;
  logic              any_c;
  logic              grant;
  logic              load;
  tx_state_e         state, state_nxt;
  logic              last_grant, last_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              src_nxt;

  assign push0 = in0_valid && in0_ready;
  assign push1 = in1_valid && in1_ready;
  assign any_c = !empty0_c || !empty1_c;

  uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(uart_samplig_clk), .reset(reset),
    .push(push0), .push_data(in0_data),
    .pop(pop0), .pop_data_c(data0_c),
    .ready(in0_ready), .full_c(full0_c), .empty_c(empty0_c), .count(count0)
  );

  uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(uart_samplig_clk), .reset(reset),
    .push(push1), .push_data(in1_data),
    .pop(pop1), .pop_data_c(data1_c),
    .ready(in1_ready), .full_c(full1_c), .empty_c(empty1_c), .count(count1)
  );

  // Next-state, grant and output-register load.
  always_comb begin
    state_nxt = state;
    data_nxt  = tx_data;
    src_nxt   = tx_src;
    last_nxt  = last_grant;
    load      = 1'b0;
    pop0      = 1'b0;
    pop1      = 1'b0;
    grant     = pick_grant(!empty0_c, !empty1_c, last_grant);
    case (state)
      ST_IDLE: load = any_c;
      ST_PRESENT: begin
        if (tx_ready) begin
          load = any_c;
          if (!any_c) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (load) begin
      state_nxt = ST_PRESENT;
      data_nxt  = grant ? data1_c : data0_c;
      src_nxt   = grant;
      last_nxt  = grant;
      pop0      = !grant;
      pop1      = grant;
    end
  end

  always_ff @(posedge uart_samplig_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tx_data    <= '0;
      tx_src     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      tx_data    <= data_nxt;
      tx_src     <= src_nxt;
      last_grant <= last_nxt;
    end
  end

  assign tx_valid = (state == ST_PRESENT);

  // A full FIFO must never advertise room, and occupancy never exceeds DEPTH.
  a_full0: assert property (@(posedge uart_samplig_clk) disable iff (reset)
                            full0_c |-> !in0_ready);
  a_full1: assert property (@(posedge uart_samplig_clk) disable iff (reset)
                            full1_c |-> !in1_ready);
  a_cnt: assert property (@(posedge uart_samplig_clk) disable iff (reset)
                          (count0 <= CNT_W'(DEPTH)) && (count1 <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference.
module tb_uart_tx_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in0_valid, in0_ready, in1_valid, in1_ready;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              tx_valid, tx_ready, tx_src;
  logic [DATA_W-1:0] tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .uart_samplig_clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_src(tx_src)
  );

  // Reference: two queues plus the byte on offer; obs logs {src,data} of each DUT handshake.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_present = 1'b0;
  logic [7:0] m_data    = 8'h00;
  logic       m_src     = 1'b0;
  logic       m_last    = 1'b1;
  logic       m_rst_prev = 1'b1;
  logic [8:0] obs[$];

  function automatic logic m_ready0();
    return !m_rst_prev && (q0.size() < int'(DEPTH));
  endfunction

  function automatic logic m_ready1();
    return !m_rst_prev && (q1.size() < int'(DEPTH));
  endfunction

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic tr);
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; tx_ready = tr;
  endtask

  task automatic tick();
    logic h0, h1, g;
    @(posedge clk);
    if (reset) begin
      q0.delete(); q1.delete();
      m_present = 1'b0; m_data = 8'h00; m_src = 1'b0; m_last = 1'b1; m_rst_prev = 1'b1;
    end else begin
      h0 = in0_valid && m_ready0();
      h1 = in1_valid && m_ready1();
      if (tx_valid && tx_ready) obs.push_back({tx_src, tx_data});
      if ((!m_present || tx_ready) && (q0.size() > 0 || q1.size() > 0)) begin
        g = (q0.size() > 0 && q1.size() > 0) ? !m_last : (q1.size() > 0);
        if (g) m_data = q1.pop_front();
        else   m_data = q0.pop_front();
        m_src = g; m_last = g; m_present = 1'b1;
      end else if (m_present && tx_ready) begin
        m_present = 1'b0;
      end
      if (h0) q0.push_back(in0_data);
      if (h1) q1.push_back(in1_data);
      m_rst_prev = 1'b0;
    end
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1; drive(0, 8'h00, 0, 8'h00, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; drive(0, 8'h00, 0, 8'h00, 1);
    tick(); tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (tx_src !== 1'b0) begin n_fail++; $display("FAIL reset_tx_src: got %b want 0", tx_src); end
    n_checks++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in0_ready: got %b want 0", in0_ready); end
    n_checks++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in1_ready: got %b want 0", in1_ready); end
    reset = 1'b0;
    tick();
    n_checks++; if (in0_ready !== 1'b1) begin n_fail++; $display("FAIL release_in0_ready: got %b want 1", in0_ready); end
    n_checks++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL release_in1_ready: got %b want 1", in1_ready); end
  endtask

  task automatic test_single();
    reset_pulse();
    obs.delete();
    drive(1, 8'h48, 0, 8'h00, 1);
    tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_same_edge: got %b want 0", tx_valid); end
    drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", tx_valid); end
    n_checks++; if (tx_data !== 8'h48) begin n_fail++; $display("FAIL single_data: got %h want 48", tx_data); end
    n_checks++; if (tx_src !== 1'b0) begin n_fail++; $display("FAIL single_src: got %b want 0", tx_src); end
    tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", tx_valid); end
    n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", obs.size()); end
  endtask

  task automatic test_contention();
    logic [8:0] exp [4];
    exp[0] = 9'h041; exp[1] = 9'h161; exp[2] = 9'h042; exp[3] = 9'h162;
    reset_pulse();
    obs.delete();
    drive(1, 8'h41, 1, 8'h61, 1);
    tick();
    drive(1, 8'h42, 1, 8'h62, 1);
    tick();
    n_checks++; if (tx_data !== 8'h41 || tx_src !== 1'b0) begin n_fail++; $display("FAIL cont_first: got %b/%h want 0/41", tx_src, tx_data); end
    drive(0, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL cont_b2b[%0d]: got %b want 1", i, tx_valid); end
    end
    tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL cont_idle: got %b want 0", tx_valid); end
    n_checks++; if (obs.size() != 4) begin n_fail++; $display("FAIL cont_count: got %0d want 4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp[i]) begin n_fail++; $display("FAIL cont_order[%0d]: got %h want %h", i, obs[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    reset_pulse();
    obs.delete();
    drive(1, 8'h11, 0, 8'h00, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h00, 1, 8'hA0 + 8'(k), 0);
      tick();
    end
    n_checks++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in1_ready); end
    drive(0, 8'h00, 1, 8'hA4, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (tx_data !== 8'h11 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall[%0d]: got %b/%h want 1/11", k, tx_valid, tx_data); end
      n_checks++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_refuse[%0d]: got %b want 0", k, in1_ready); end
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    n_checks++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", in1_ready); end
    n_checks++; if (tx_data !== 8'hA0 || tx_src !== 1'b1) begin n_fail++; $display("FAIL bp_next: got %b/%h want 1/a0", tx_src, tx_data); end
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (obs.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", obs.size()); end
    for (int i = 1; i < 5 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== {1'b1, 8'hA0 + 8'(i - 1)}) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs[i], {1'b1, 8'hA0 + 8'(i - 1)}); end
    end
  endtask

  task automatic test_wrap();
    int  nxt = 0;
    int  cyc = 0;
    logic acc;
    reset_pulse();
    obs.delete();
    while (obs.size() < 10 && cyc < 400) begin
      drive((nxt < 10) && ($urandom_range(0, 3) != 0), 8'(nxt), 0, 8'h00, 1'($urandom_range(0, 1)));
      acc = in0_valid && m_ready0();
      tick();
      if (acc) nxt++;
      cyc++;
    end
    n_checks++; if (obs.size() != 10) begin n_fail++; $display("FAIL wrap_count: got %0d want 10", obs.size()); end
    for (int i = 0; i < 10 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== {1'b0, 8'(i)}) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i, obs[i], {1'b0, 8'(i)}); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'hC0 + 8'(k), 0, 8'h00, 0);
      tick();
    end
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b want 1", tx_valid); end
    reset = 1'b1; drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    reset = 1'b0;
    n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_clear: got %b/%h want 0/00", tx_valid, tx_data); end
    obs.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (tx_valid) seen++;
    end
    n_checks++; if (seen != 0 || obs.size() != 0) begin n_fail++; $display("FAIL rmid_silent: got %0d valid cycles want 0", seen); end
    drive(0, 8'h00, 1, 8'h55, 1);
    tick();
    drive(0, 8'h00, 0, 8'h00, 1);
    tick();
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h55 || tx_src !== 1'b1) begin n_fail++; $display("FAIL rmid_new: got %b/%b/%h want 1/1/55", tx_valid, tx_src, tx_data); end
    tick();
    n_checks++; if (obs.size() != 1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", obs.size()); end
  endtask

  task automatic test_random();
    int p_in, p_tx;
    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        p_in = $urandom_range(1, 9);
        p_tx = $urandom_range(1, 9);
      end
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < p_in, 8'($urandom), $urandom_range(0, 9) < p_in,
            8'($urandom), $urandom_range(0, 9) < p_tx);
      tick();
      n_checks++; if (tx_valid !== m_present) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, tx_valid, m_present); end
      n_checks++; if (in0_ready !== m_ready0()) begin n_fail++; $display("FAIL rnd_in0_ready@%0d: got %b want %b", c, in0_ready, m_ready0()); end
      n_checks++; if (in1_ready !== m_ready1()) begin n_fail++; $display("FAIL rnd_in1_ready@%0d: got %b want %b", c, in1_ready, m_ready1()); end
      if (m_present || m_rst_prev) begin
        n_checks++; if (tx_data !== m_data) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, tx_data, m_data); end
        n_checks++; if (tx_src !== m_src) begin n_fail++; $display("FAIL rnd_src@%0d: got %b want %b", c, tx_src, m_src); end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
